cpu_result_capture: RTL and testbench

Downstream observer of the cpu core. Watches hlt and the architectural registers (X, Y, ACC, PC, flags). On halt, or on watchdog expiry, it snapshots the registers and streams them as a framed sequence of 16-bit words over a valid/ready handshake to a host, logger or UART bridge. It replaces ad-hoc end-of-simulation register dumps with a synthesizable result path.

---
 rtl/cpu_result_capture.sv | 136 +++++++++++++
 tb/tb_cpu_result_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_result_capture.sv
// Captures the cpu's architectural registers on halt or watchdog expiry and streams them
// as a framed valid/ready word sequence. Define CAPTURE_CYCLE_COUNT_EN to append a 32-bit RUN cycle count.
module cpu_result_capture #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter logic [7:0]  HDR_TAG        = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hlt,
    input  logic [9:0]  PC,
    input  logic [3:0]  flags,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [15:0] ACC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        done
);

    typedef enum logic [1:0] {RUN, SEND, DONE} state_t;

    localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT_CYCLES - 1);
`ifdef CAPTURE_CYCLE_COUNT_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif
    localparam logic [5:0] N_PAYLOAD = {3'b000, LAST_IDX};

    state_t             state;
    logic [2:0]         idx;
    logic [2:0]         nxt_idx;
    logic [23:0]        wd;
    logic               timeout_hit;
    logic signed [15:0] snap_x;
    logic signed [15:0] snap_y;
    logic signed [15:0] snap_acc;
    logic [9:0]         snap_pc;
    logic [3:0]         snap_flags;
    logic               halted;
    logic               timed_out;
    logic [15:0]        word_nxt;
`ifdef CAPTURE_CYCLE_COUNT_EN
    logic [31:0]        cyc_cnt;
`endif

    function automatic logic [15:0] header_word(input logic t, input logic h);
        return {HDR_TAG, N_PAYLOAD, t, h};
    endfunction

    // Next frame word comes from the frozen snapshot, so inputs are ignored once SEND starts.
    always_comb begin
        nxt_idx     = idx + 3'd1;
        timeout_hit = (wd == WD_LIMIT);
        word_nxt    = 16'h0000;
        case (nxt_idx)
            3'd0: word_nxt = header_word(timed_out, halted);
            3'd1: word_nxt = snap_x;
            3'd2: word_nxt = snap_y;
            3'd3: word_nxt = snap_acc;
            3'd4: word_nxt = {snap_pc, snap_flags, 2'b00};
`ifdef CAPTURE_CYCLE_COUNT_EN
            3'd5: word_nxt = cyc_cnt[31:16];
            3'd6: word_nxt = cyc_cnt[15:0];
`endif
            default: word_nxt = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= 16'h0000;
            done       <= 1'b0;
            idx        <= 3'd0;
            wd         <= 24'd0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_acc   <= '0;
            snap_pc    <= '0;
            snap_flags <= '0;
            halted     <= 1'b0;
            timed_out  <= 1'b0;
`ifdef CAPTURE_CYCLE_COUNT_EN
            cyc_cnt    <= 32'd0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (hlt || timeout_hit) begin
                        snap_x     <= X;
                        snap_y     <= Y;
                        snap_acc   <= ACC;
                        snap_pc    <= PC;
                        snap_flags <= flags;
                        halted     <= hlt;
                        timed_out  <= timeout_hit;
                        idx        <= 3'd0;
                        out_valid  <= 1'b1;
                        out_last   <= 1'b0;
                        out_data   <= header_word(timeout_hit, hlt);
                        state      <= SEND;
                    end else begin
                        wd <= wd + 24'd1;
`ifdef CAPTURE_CYCLE_COUNT_EN
                        if (cyc_cnt != 32'hFFFF_FFFF)
                            cyc_cnt <= cyc_cnt + 32'd1;
`endif
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx      <= nxt_idx;
                            out_data <= word_nxt;
                            out_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_result_capture.sv
// Randomized scoreboard bench for cpu_result_capture: driver predicts frames from the
// register values at the capture edge, a negedge monitor pops and compares every accepted word.
module tb_cpu_result_capture;

    localparam int T = 16;
`ifdef CAPTURE_CYCLE_COUNT_EN
    localparam int NPAY = 6;
`else
    localparam int NPAY = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        hlt;
    logic [9:0]  PC;
    logic [3:0]  flags;
    logic [15:0] X;
    logic [15:0] Y;
    logic [15:0] ACC;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        done;

    always #5 clk = ~clk;

    cpu_result_capture #(.TIMEOUT_CYCLES(T), .HDR_TAG(8'hA5)) dut (
        .clk(clk), .reset(reset), .hlt(hlt), .PC(PC), .flags(flags),
        .X(X), .Y(Y), .ACC(ACC),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] exp_q[$];
    bit          m_run = 1'b1;
    int          m_wd = 0;
    logic [31:0] m_cnt = 32'd0;
    bit          pend_done = 1'b0;
    bit          hold_v = 1'b0;
    logic [15:0] hold_d = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame from plain rules: header, X, Y, ACC, {PC,flags,00}, optional count words.
    task automatic push_frame(input logic [15:0] hdr);
        logic [15:0] w[7];
        w[0] = hdr;
        w[1] = X;
        w[2] = Y;
        w[3] = ACC;
        w[4] = {PC, flags, 2'b00};
        w[5] = m_cnt[31:16];
        w[6] = m_cnt[15:0];
        for (int i = 0; i <= NPAY; i++)
            exp_q.push_back({(i == NPAY), w[i]});
    endtask

    task automatic do_edge();
        bit          cap = 1'b0;
        logic [15:0] hdr = 16'h0;
        logic        tbit;
        if (!reset && m_run) begin
            tbit = (m_wd == T - 1);
            if (hlt || tbit) begin
                hdr = {8'hA5, 6'(NPAY), tbit, hlt};
                push_frame(hdr);
                m_run = 1'b0;
                cap = 1'b1;
            end else begin
                m_wd++;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (cap) begin
            check("latency_valid", out_valid, 1);
            check("latency_header", out_data, hdr);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < cycles; i++) do_edge();
        m_run = 1'b1;
        m_wd = 0;
        m_cnt = 32'd0;
        reset = 1'b0;
        check("reset_valid", out_valid, 0);
        check("reset_done", done, 0);
        check("reset_last", out_last, 0);
        check("reset_data", out_data, 16'h0000);
    endtask

    task automatic rand_regs();
        X = 16'($urandom);
        Y = 16'($urandom);
        ACC = 16'($urandom);
        PC = 10'($urandom);
        flags = 4'($urandom);
    endtask

    // mode 0: always ready, 1: 1,0,0 pattern, 2: random, 3: ready only for first two words
    task automatic run_frame(input int hlt_cyc, input int mode, input bit rnd, input int abort_at);
        int since = -1;
        int cyc = 0;
        forever begin
            if (rnd) rand_regs();
            hlt = (hlt_cyc >= 0 && cyc >= hlt_cyc);
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                2: out_ready = ($urandom % 4 != 0);
                default: out_ready = (since >= 0 && since < 2);
            endcase
            if (abort_at >= 0 && since == abort_at) begin
                do_reset(1);
                return;
            end
            do_edge();
            if (since >= 0) since++;
            else if (!m_run) since = 0;
            cyc++;
            if (!m_run && exp_q.size() == 0 && !pend_done && since > 0) break;
            if (cyc > 300) begin
                check("frame_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic post_done_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            hlt = 1'($urandom);
            out_ready = 1'b1;
            do_edge();
            check("post_done_valid", out_valid, 0);
            check("post_done_done", done, 1);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (reset) begin
            hold_v = 1'b0;
            pend_done = 1'b0;
        end else begin
            if (pend_done) begin
                check("done_set", done, 1);
                check("valid_drop", out_valid, 0);
                pend_done = 1'b0;
            end
            if (hold_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hold_d);
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_word: got %h expected no word", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", out_data, e[15:0]);
                        check("last", out_last, e[16]);
                        if (e[16]) pend_done = 1'b1;
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hold_d = out_data;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        int h;
        int md;
        int ab;
        reset = 1'b1;
        hlt = 1'b0;
        out_ready = 1'b0;
        X = 16'h0005; Y = 16'hFFFD; ACC = 16'h0002; PC = 10'h03C; flags = 4'b1001;
        do_reset(2);

        run_frame(10, 0, 1'b0, -1);
        post_done_pulses(6);

        do_reset(1);
        run_frame(10, 1, 1'b0, -1);

        do_reset(1);
        run_frame(-1, 2, 1'b1, -1);

        do_reset(1);
        run_frame(T - 1, 0, 1'b1, -1);

        do_reset(1);
        X = 16'h1234; Y = 16'h8001; ACC = 16'h7FFF; PC = 10'h3FF; flags = 4'b0110;
        run_frame(3, 3, 1'b0, 4);
        run_frame(5, 0, 1'b1, -1);
        post_done_pulses(4);

        for (int it = 0; it < 10; it++) begin
            do_reset(1);
            h = $urandom_range(0, 24);
            if (h > 20) h = -1;
            md = $urandom_range(0, 2);
            ab = ($urandom % 4 == 0) ? $urandom_range(0, 5) : -1;
            run_frame(h, md, 1'b1, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
